// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one 16-bit signed iterative divider among NUM_REQ requesters.
// A zero divisor is trapped before issue and answered with a saturated result and div0 set.
module div_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] dividend,
    input  logic [16*NUM_REQ-1:0] divisor,
    output logic [NUM_REQ-1:0]    done,
    output logic [15:0]           result,
    output logic                  div0,
    output logic                  busy,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  div_go,
    output logic [15:0]           div_dividend,
    output logic [15:0]           div_divisor,
    input  logic [15:0]           div_quotient,
    input  logic                  div_rdy
);

    // state | meaning
    // IDLE  | waiting for any request; arbitration and operand latch happen here
    // ISSUE | one-cycle div_go to the divider
    // WAIT  | waiting for div_rdy
    // RESP  | done pulse to the granted requester
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic [15:0]        r_result;
    logic               r_div0;

    logic               w_any;
    logic [IDX_W-1:0]   w_sel;
    logic [15:0]        w_a;
    logic [15:0]        w_b;
    logic [15:0]        w_sat;
    logic [NUM_REQ-1:0] w_done;

    // Descending scan so the requester closest to the pointer wins.
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_sel = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == i[IDX_W-1:0]) begin
                w_a = dividend[i*16 +: 16];
                w_b = divisor[i*16 +: 16];
            end
        end
        w_sat = w_a[15] ? 16'h8000 : 16'h7FFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_done = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_next = (w_b == 16'd0) ? S_RESP : S_ISSUE;
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (div_rdy) w_next = S_RESP;
            end
            S_RESP: begin
                w_done[r_grant] = 1'b1;
                w_next          = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_grant  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_a     <= w_a;
                        r_b     <= w_b;
                        if (w_b == 16'd0) begin
                            r_result <= w_sat;
                            r_div0   <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (div_rdy) begin
                        r_result <= div_quotient;
                        r_div0   <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done         = w_done;
    assign result       = r_result;
    assign div0         = r_div0;
    assign busy         = (r_state != S_IDLE);
    assign grant_idx    = r_grant;
    assign div_go       = (r_state == S_ISSUE);
    assign div_dividend = r_a;
    assign div_divisor  = r_b;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural iterative divider attached.
module tb_div_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic [3:0]  done;
    logic [15:0] result;
    logic        div0;
    logic        busy;
    logic [1:0]  grant_idx;
    logic        div_go;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic [15:0] div_quotient;
    logic        div_rdy;

    int total = 0;
    int bad = 0;
    int go_cnt = 0;

    div_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dividend(dividend), .divisor(divisor),
        .done(done), .result(result), .div0(div0), .busy(busy), .grant_idx(grant_idx),
        .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_rdy(div_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (div_go) go_cnt++;

    // Divider model: rdy low out of reset, clears after go, sets after a quotient-dependent latency.
    logic [15:0] m_q;
    logic        m_rdy;
    logic        m_run;
    int          m_cnt;

    function automatic int lat_of(logic [15:0] a, logic [15:0] b);
        int qi;
        qi = int'($signed(a)) / int'($signed(b));
        if (qi < 0) qi = -qi;
        return ((qi > 20) ? 20 : qi) + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy <= 1'b0; m_q <= '0; m_run <= 1'b0; m_cnt <= 0;
        end else if (div_go) begin
            m_rdy <= 1'b0;
            m_run <= 1'b1;
            if (div_divisor != 16'd0) begin
                m_q   <= 16'(int'($signed(div_dividend)) / int'($signed(div_divisor)));
                m_cnt <= lat_of(div_dividend, div_divisor);
            end
        end else if (m_run) begin
            if (m_cnt == 0) begin
                m_rdy <= 1'b1; m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign div_quotient = m_q;
    assign div_rdy      = m_rdy;

    task automatic set_op(input int i, input int a, input int b);
        dividend[i*16 +: 16] = 16'(a);
        divisor[i*16 +: 16]  = 16'(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic ok, output logic [3:0] d, output logic [15:0] r,
                             output logic z, output logic [1:0] g);
        int c;
        ok = 1'b0; d = '0; r = '0; z = 1'b0; g = '0; c = 0;
        while (!ok && c < 200) begin
            tick();
            if (done != 4'd0) begin
                ok = 1'b1; d = done; r = result; z = div0; g = grant_idx;
            end
            c++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; dividend = '0; divisor = '0;
        repeat (3) tick();
        total++; if (done !== 4'd0) begin bad++; $display("FAIL rst_done got=%b want=0000", done); end
        total++; if (result !== 16'd0) begin bad++; $display("FAIL rst_result got=%h want=0000", result); end
        total++; if (div0 !== 1'b0) begin bad++; $display("FAIL rst_div0 got=%b want=0", div0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL rst_grant got=%0d want=0", grant_idx); end
        total++; if (div_go !== 1'b0) begin bad++; $display("FAIL rst_go got=%b want=0", div_go); end
        total++; if (div_dividend !== 16'd0 || div_divisor !== 16'd0) begin
            bad++; $display("FAIL rst_operands got=%h/%h want=0000/0000", div_dividend, div_divisor);
        end
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_single();
        logic ok; logic [3:0] d; logic [15:0] r; logic z; logic [1:0] g; int g0;
        g0 = go_cnt;
        set_op(0, 100, 7); req = 4'b0001;
        tick();
        total++; if (div_go !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_issue go=%b busy=%b want=1/1", div_go, busy);
        end
        tick();
        total++; if (div_dividend !== 16'd100 || div_divisor !== 16'd7) begin
            bad++; $display("FAIL single_latched got=%0d/%0d want=100/7", div_dividend, div_divisor);
        end
        set_op(0, 1000, 1);
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok) begin bad++; $display("FAIL single_timeout no done within bound"); end
        total++; if (d !== 4'b0001) begin bad++; $display("FAIL single_done got=%b want=0001", d); end
        total++; if (r !== 16'd14) begin bad++; $display("FAIL single_result got=%0d want=14", r); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL single_div0 got=%b want=0", z); end
        total++; if (g !== 2'd0) begin bad++; $display("FAIL single_grant got=%0d want=0", g); end
        total++; if (go_cnt - g0 !== 1) begin bad++; $display("FAIL single_gocount got=%0d want=1", go_cnt - g0); end
        tick();
        total++; if (done !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_after done=%b busy=%b want=0000/0", done, busy);
        end
        total++; if (result !== 16'd14) begin bad++; $display("FAIL single_hold got=%0d want=14", result); end
    endtask

    task automatic test_signs();
        logic ok; logic [3:0] d; logic [15:0] r; logic z; logic [1:0] g;
        set_op(2, -100, 7); req = 4'b0100;
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || d !== 4'b0100 || g !== 2'd2) begin
            bad++; $display("FAIL signs1_done ok=%b got=%b g=%0d want=0100 g=2", ok, d, g);
        end
        total++; if (r !== 16'hFFF2 || z !== 1'b0) begin
            bad++; $display("FAIL signs1_result got=%h div0=%b want=fff2 div0=0", r, z);
        end
        tick();
        total++; if (done !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL signs1_pulse done=%b busy=%b want=0000/0", done, busy);
        end
        set_op(2, 7, -100); req = 4'b0100;
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || d !== 4'b0100) begin bad++; $display("FAIL signs2_done ok=%b got=%b want=0100", ok, d); end
        total++; if (r !== 16'd0) begin bad++; $display("FAIL signs2_result got=%h want=0000", r); end
        tick();
        total++; if (done !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL signs2_pulse done=%b busy=%b want=0000/0", done, busy);
        end
    endtask

    task automatic test_div0();
        logic ok; logic [3:0] d; logic [15:0] r; logic z; logic [1:0] g; int g0;
        g0 = go_cnt;
        set_op(1, 55, 0); req = 4'b0010;
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || d !== 4'b0010) begin bad++; $display("FAIL div0a_done ok=%b got=%b want=0010", ok, d); end
        total++; if (r !== 16'h7FFF || z !== 1'b1) begin
            bad++; $display("FAIL div0a_result got=%h div0=%b want=7fff div0=1", r, z);
        end
        tick();
        set_op(1, -3, 0); req = 4'b0010;
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || d !== 4'b0010) begin bad++; $display("FAIL div0b_done ok=%b got=%b want=0010", ok, d); end
        total++; if (r !== 16'h8000 || z !== 1'b1) begin
            bad++; $display("FAIL div0b_result got=%h div0=%b want=8000 div0=1", r, z);
        end
        total++; if (go_cnt != g0) begin bad++; $display("FAIL div0_nogo got=%0d want=0", go_cnt - g0); end
        tick();
        set_op(1, 9, 3); req = 4'b0010;
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || r !== 16'd3 || z !== 1'b0) begin
            bad++; $display("FAIL div0_clear ok=%b got=%h div0=%b want=0003 div0=0", ok, r, z);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic ok; logic [3:0] d; logic [15:0] r; logic z; logic [1:0] g;
        int eg[6] = '{0, 1, 2, 3, 0, 1};
        int er[6] = '{10, -10, 9, -3, 10, -10};
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        set_op(0, 100, 10); set_op(1, -50, 5); set_op(2, 81, 9); set_op(3, 12, -4);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_done(ok, d, r, z, g);
            if (k == 5) req = 4'b0000;
            total++; if (!ok || g !== 2'(eg[k]) || d !== 4'(1 << eg[k])) begin
                bad++; $display("FAIL rr_grant%0d ok=%b got=%0d done=%b want=%0d", k, ok, g, d, eg[k]);
            end
            total++; if (r !== 16'(er[k])) begin
                bad++; $display("FAIL rr_result%0d got=%h want=%h", k, r, 16'(er[k]));
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        logic ok; logic [3:0] d; logic [15:0] r; logic z; logic [1:0] g;
        req = 4'b0100;
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || g !== 2'd2) begin bad++; $display("FAIL wrap_setup ok=%b got=%0d want=2", ok, g); end
        tick();
        req = 4'b1001;
        wait_done(ok, d, r, z, g);
        total++; if (!ok || g !== 2'd3 || r !== 16'hFFFD) begin
            bad++; $display("FAIL wrap_first ok=%b got=%0d r=%h want=3 r=fffd", ok, g, r);
        end
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || g !== 2'd0 || r !== 16'd10) begin
            bad++; $display("FAIL wrap_second ok=%b got=%0d r=%h want=0 r=000a", ok, g, r);
        end
        tick();
        req = 4'b1001;
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || g !== 2'd3) begin bad++; $display("FAIL wrap_third ok=%b got=%0d want=3", ok, g); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic ok; logic [3:0] d; logic [15:0] r; logic z; logic [1:0] g;
        set_op(0, 30000, 1); req = 4'b0001;
        tick(); tick();
        repeat (3) tick();
        total++; if (busy !== 1'b1 || done !== 4'd0) begin
            bad++; $display("FAIL mid_waiting busy=%b done=%b want=1/0000", busy, done);
        end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || div_go !== 1'b0 || done !== 4'd0) begin
            bad++; $display("FAIL mid_ctrl busy=%b go=%b done=%b want=0/0/0000", busy, div_go, done);
        end
        total++; if (result !== 16'd0 || div0 !== 1'b0 || grant_idx !== 2'd0) begin
            bad++; $display("FAIL mid_regs result=%h div0=%b grant=%0d want=0000/0/0", result, div0, grant_idx);
        end
        total++; if (div_dividend !== 16'd0 || div_divisor !== 16'd0) begin
            bad++; $display("FAIL mid_operands got=%h/%h want=0000/0000", div_dividend, div_divisor);
        end
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        set_op(0, 9, 3); req = 4'b0001;
        wait_done(ok, d, r, z, g);
        req = 4'b0000;
        total++; if (!ok || d !== 4'b0001 || r !== 16'd3 || z !== 1'b0) begin
            bad++; $display("FAIL mid_after ok=%b done=%b r=%h div0=%b want=0001 r=0003 div0=0", ok, d, r, z);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_signs();
        test_div0();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
